// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory port-B bus: control-bit layout and arbiter states.
package mem_bus_pkg;

   localparam int CTRL_W    = 4;
   localparam int CTRL_WE   = 3;
   localparam int CTRL_HALF = 2;
   localparam int CTRL_BYTE = 1;
   localparam int CTRL_EXT  = 0;

   typedef enum logic {
      ARB,
      LOCK
   } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 8
) (
   input  logic             clk,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   assign at_limit = (count == WIDTH'(LIMIT));

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Port-B arbiter: CPU has fixed priority over DMA, bounded by a starvation limit;
// DMA may lock the port for bursts of at most LOCK_MAX granted beats.
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int LOCK_MAX     = 16
) (
   input  logic              clk,
   input  logic              init,
   input  logic              cpu_req,
   input  logic [AW-1:0]     cpu_addr,
   input  logic [DW-1:0]     cpu_wdata,
   input  logic [CTRL_W-1:0] cpu_ctrl,
   output logic              cpu_ack,
   output logic [DW-1:0]     cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic [AW-1:0]     dma_addr,
   input  logic [DW-1:0]     dma_wdata,
   input  logic [CTRL_W-1:0] dma_ctrl,
   output logic              dma_ack,
   output logic [DW-1:0]     dma_rdata,
   output logic              dma_rvalid,
   input  logic              dma_lock,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [CTRL_W-1:0] mem_ctrl,
   input  logic [DW-1:0]     mem_rdata,
   output logic              grant_dma
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

   arbState_t           state;
   logic                cpuWin;
   logic                dmaWin;
   logic                lockBeat;
   logic                lockFull;
   logic                holdLock;
   logic [STARVE_W-1:0] starveCnt;
   logic                starveAtLimit;
   logic [LOCK_W-1:0]   lockCnt;
   logic                lockAtLimit;

   always_comb begin
      cpuWin = 1'b0;
      dmaWin = 1'b0;
      if (!init) begin
         if (state == LOCK) begin
            dmaWin = dma_req;
         end else if (dma_req && (starveAtLimit || !cpu_req)) begin
            dmaWin = 1'b1;
         end else begin
            cpuWin = cpu_req;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_ctrl  = '0;
      if (cpuWin) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_ctrl  = cpu_ctrl;
      end else if (dmaWin) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_ctrl  = dma_ctrl;
      end
   end

   assign cpu_ack   = cpuWin;
   assign dma_ack   = dmaWin;
   assign grant_dma = dmaWin;

   // A beat counts toward the burst when it opens a lock from ARB or lands inside one;
   // the beat that would reach LOCK_MAX ends the burst instead of staying locked.
   assign lockBeat = dmaWin && (state == LOCK || dma_lock);
   assign lockFull = (lockCnt == LOCK_W'(LOCK_MAX - 1));
   assign holdLock = (state == LOCK) ? (dma_lock && !(lockBeat && lockFull))
                                     : (lockBeat && !lockFull);

   sat_counter #(
      .WIDTH (STARVE_W),
      .LIMIT (STARVE_LIMIT)
   ) starveCounter (
      .clk      (clk),
      .inc      (dma_req && !dmaWin),
      .clr      (init || dmaWin || !dma_req),
      .count    (starveCnt),
      .at_limit (starveAtLimit)
   );

   sat_counter #(
      .WIDTH (LOCK_W),
      .LIMIT (LOCK_MAX)
   ) lockCounter (
      .clk      (clk),
      .inc      (lockBeat),
      .clr      (init || !holdLock),
      .count    (lockCnt),
      .at_limit (lockAtLimit)
   );

   always_ff @(posedge clk) begin
      if (init) begin
         state <= ARB;
      end else begin
         state <= holdLock ? LOCK : ARB;
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         dma_rdata  <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpuWin && !cpu_ctrl[CTRL_WE];
         dma_rvalid <= dmaWin && !dma_ctrl[CTRL_WE];
         if (cpuWin && !cpu_ctrl[CTRL_WE]) begin
            cpu_rdata <= mem_rdata;
         end
         if (dmaWin && !dma_ctrl[CTRL_WE]) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

   // A lock always exits on the beat that reaches LOCK_MAX, so a full count is never held.
   assert property (@(posedge clk) disable iff (init) starveCnt <= STARVE_W'(STARVE_LIMIT));
   assert property (@(posedge clk) disable iff (init) !(state == LOCK && lockAtLimit));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model and a small word-addressed memory.
module tb_mem_port_arbiter;
   import mem_bus_pkg::*;

   localparam int AW           = 32;
   localparam int DW           = 32;
   localparam int STARVE_LIMIT = 8;
   localparam int LOCK_MAX     = 16;

   logic          clk = 1'b0;
   logic          init;
   logic          cpu_req,  dma_req, dma_lock;
   logic [31:0]   cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [3:0]    cpu_ctrl, dma_ctrl;
   logic          cpu_ack,  dma_ack, cpu_rvalid, dma_rvalid, grant_dma;
   logic [31:0]   cpu_rdata, dma_rdata;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;
   logic [3:0]    mem_ctrl;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW           (AW),
      .DW           (DW),
      .STARVE_LIMIT (STARVE_LIMIT),
      .LOCK_MAX     (LOCK_MAX)
   ) dut (
      .clk        (clk),
      .init       (init),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ctrl   (cpu_ctrl),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_ctrl   (dma_ctrl),
      .dma_ack    (dma_ack),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .dma_lock   (dma_lock),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ctrl   (mem_ctrl),
      .mem_rdata  (mem_rdata),
      .grant_dma  (grant_dma)
   );

   // Port-B memory stub: 64 words, combinational read, write on the edge; preload port for setup.
   logic [31:0] memArr [64];
   logic        pWe;
   logic [5:0]  pIdx;
   logic [31:0] pData;

   always @(posedge clk) begin
      if (pWe) memArr[pIdx] <= pData;
      else if (mem_ctrl[CTRL_WE]) memArr[mem_addr[7:2]] <= mem_wdata;
   end
   assign mem_rdata = memArr[mem_addr[7:2]];

   // Reference model state.
   logic [31:0] mRef [64];
   int          mStarve = 0;
   int          mBeats  = 0;
   bit          mLocked = 1'b0;
   logic [31:0] eCpuRd = '0, eDmaRd = '0;
   logic        eCpuRv = 1'b0, eDmaRv = 1'b0;

   int checks = 0;
   int errors = 0;

   // 0: nobody, 1: CPU, 2: DMA
   function automatic int expWinner();
      if (init) return 0;
      if (mLocked) return dma_req ? 2 : 0;
      if (dma_req && mStarve >= STARVE_LIMIT) return 2;
      if (cpu_req) return 1;
      if (dma_req) return 2;
      return 0;
   endfunction

   // Advance the model with the currently driven inputs, then move to the next cycle's drive point.
   task automatic tick();
      int w;
      w = expWinner();
      if (init) begin
         mStarve = 0; mLocked = 1'b0; mBeats = 0;
         eCpuRv = 1'b0; eDmaRv = 1'b0; eCpuRd = '0; eDmaRd = '0;
      end else begin
         eCpuRv = 1'b0;
         eDmaRv = 1'b0;
         if (w == 1) begin
            if (cpu_ctrl[3]) mRef[cpu_addr[7:2]] = cpu_wdata;
            else begin eCpuRv = 1'b1; eCpuRd = mRef[cpu_addr[7:2]]; end
         end
         if (w == 2) begin
            if (dma_ctrl[3]) mRef[dma_addr[7:2]] = dma_wdata;
            else begin eDmaRv = 1'b1; eDmaRd = mRef[dma_addr[7:2]]; end
         end
         if (w == 2 || !dma_req) mStarve = 0;
         else if (mStarve < STARVE_LIMIT) mStarve++;
         if (mLocked) begin
            if (w == 2) mBeats++;
            if (mBeats == LOCK_MAX) begin
               mLocked = 1'b0; mBeats = 0; mStarve = 0;
            end else if (!dma_lock) begin
               mLocked = 1'b0; mBeats = 0;
            end
         end else if (w == 2 && dma_lock) begin
            mBeats  = 1;
            mLocked = (LOCK_MAX > 1);
            if (!mLocked) begin mBeats = 0; mStarve = 0; end
         end
      end
      if (pWe) mRef[pIdx] = pData;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; cpu_ctrl = '0;
      dma_addr = '0; dma_wdata = '0; dma_ctrl = '0;
   endtask

   task automatic preload();
      init = 1'b1;
      idle();
      for (int i = 0; i < 64; i++) begin
         pWe = 1'b1; pIdx = 6'(i);
         pData = (i == 4) ? 32'hDEADBEEF : $urandom;
         tick();
      end
      pWe = 1'b0;
   endtask

   task automatic test_reset();
      init = 1'b1;
      cpu_req = 1'b1; dma_req = 1'b1;
      cpu_addr = 32'h14; dma_addr = 32'h18;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || grant_dma !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks cyc %0d got cpu %b dma %b grant %b exp 0 0 0", c, cpu_ack, dma_ack, grant_dma);
         end
         checks++;
         if (mem_ctrl !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem cyc %0d got ctrl %b addr %h wdata %h exp zeros", c, mem_ctrl, mem_addr, mem_wdata);
         end
         checks++;
         if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd cyc %0d got rv %b/%b rd %h/%h exp 0/0 0/0", c, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
         end
         tick();
      end
      init = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_addr = 32'h10; cpu_ctrl = 4'b0000;
      #1;
      checks++;
      if (cpu_ack !== 1'b1 || mem_addr !== 32'h10 || dma_ack !== 1'b0) begin
         errors++;
         $display("FAIL cpu_read_ack got ack %b addr %h dma_ack %b exp 1 00000010 0", cpu_ack, mem_addr, dma_ack);
      end
      tick();
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL cpu_read_data got rv %b rd %h dma_rv %b exp 1 deadbeef 0", cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      tick();
   endtask

   task automatic test_contention();
      logic expCpu, expDma;
      cpu_req = 1'b1; cpu_addr = 32'h20; cpu_ctrl = 4'b0000;
      dma_req = 1'b1; dma_addr = 32'h24; dma_ctrl = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         expDma = (c == STARVE_LIMIT);
         expCpu = !expDma;
         #1;
         checks++;
         if (cpu_ack !== expCpu || dma_ack !== expDma || grant_dma !== expDma) begin
            errors++;
            $display("FAIL contention cyc %0d got cpu %b dma %b grant %b exp %b %b %b",
                     c, cpu_ack, dma_ack, grant_dma, expCpu, expDma, expDma);
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_dma_write();
      dma_req = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hA5A5A5A5; dma_ctrl = 4'b1000;
      #1;
      checks++;
      if (dma_ack !== 1'b1 || mem_ctrl !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL dma_write_cycle got ack %b ctrl %b wdata %h exp 1 1000 a5a5a5a5", dma_ack, mem_ctrl, mem_wdata);
      end
      tick();
      idle();
      #1;
      checks++;
      if (mem_ctrl !== 4'b0000 || dma_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL dma_write_after got ctrl %b dma_rv %b exp 0000 0", mem_ctrl, dma_rvalid);
      end
      tick();
      cpu_req = 1'b1; cpu_addr = 32'h40; cpu_ctrl = 4'b0000;
      tick();
      idle();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL dma_write_readback got rv %b rd %h exp 1 a5a5a5a5", cpu_rvalid, cpu_rdata);
      end
      tick();
   endtask

   task automatic test_lock_burst();
      int dmaAcks = 0;
      int cpuAt = -1;
      dma_lock = 1'b1; dma_req = 1'b1; dma_addr = 32'h80;
      cpu_addr = 32'h84;
      for (int c = 0; c < 24 && cpuAt < 0; c++) begin
         cpu_req = (c >= 1);
         #1;
         if (dma_ack === 1'b1) dmaAcks++;
         if (cpu_ack === 1'b1) cpuAt = c;
         tick();
      end
      checks++;
      if (dmaAcks != LOCK_MAX) begin
         errors++;
         $display("FAIL lock_burst_beats got %0d exp %0d", dmaAcks, LOCK_MAX);
      end
      checks++;
      if (cpuAt != LOCK_MAX) begin
         errors++;
         $display("FAIL lock_burst_cpu_cycle got %0d exp %0d", cpuAt, LOCK_MAX);
      end
      // starvation was cleared by the forced exit: CPU keeps winning for now
      #1;
      checks++;
      if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin
         errors++;
         $display("FAIL lock_burst_starve_clear got cpu %b dma %b exp 1 0", cpu_ack, dma_ack);
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_lock_drop_init();
      int dmaAcks = 0;
      dma_lock = 1'b1; dma_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cpu_req = (c >= 1);
         #1;
         if (dma_ack === 1'b1 && cpu_ack === 1'b0) dmaAcks++;
         tick();
      end
      checks++;
      if (dmaAcks != 3) begin
         errors++;
         $display("FAIL lock_drop_beats got %0d exp 3", dmaAcks);
      end
      dma_lock = 1'b0;
      #1;
      checks++;
      if (cpu_ack !== 1'b0 || dma_ack !== 1'b1) begin
         errors++;
         $display("FAIL lock_drop_fall got cpu %b dma %b exp 0 1", cpu_ack, dma_ack);
      end
      tick();
      #1;
      checks++;
      if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin
         errors++;
         $display("FAIL lock_drop_after got cpu %b dma %b exp 1 0", cpu_ack, dma_ack);
      end
      tick();
      idle();
      tick();
      dma_lock = 1'b1; dma_req = 1'b1;
      tick();
      cpu_req = 1'b1;
      tick();
      init = 1'b1;
      #1;
      checks++;
      if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || mem_ctrl !== 4'b0) begin
         errors++;
         $display("FAIL init_mid_lock got cpu %b dma %b ctrl %b exp 0 0 0000", cpu_ack, dma_ack, mem_ctrl);
      end
      tick();
      init = 1'b0;
      #1;
      checks++;
      if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin
         errors++;
         $display("FAIL init_back_to_arb got cpu %b dma %b dma_rv %b dma_rd %h exp 1 0 0 0",
                  cpu_ack, dma_ack, dma_rvalid, dma_rdata);
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_random();
      int w;
      logic [31:0] eAddr, eWdata;
      logic [3:0]  eCtrl;
      for (int c = 0; c < 600; c++) begin
         init    = ($urandom_range(0, 59) == 0);
         cpu_req = ($urandom_range(0, 9) < 6);
         dma_req = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0) dma_lock = ~dma_lock;
         cpu_addr = $urandom; cpu_addr[1:0] = 2'b00;
         dma_addr = $urandom; dma_addr[1:0] = 2'b00;
         cpu_wdata = $urandom; dma_wdata = $urandom;
         cpu_ctrl = 4'($urandom); dma_ctrl = 4'($urandom);
         #1;
         w = expWinner();
         eAddr  = (w == 1) ? cpu_addr  : (w == 2) ? dma_addr  : 32'h0;
         eWdata = (w == 1) ? cpu_wdata : (w == 2) ? dma_wdata : 32'h0;
         eCtrl  = (w == 1) ? cpu_ctrl  : (w == 2) ? dma_ctrl  : 4'h0;
         checks++;
         if (cpu_ack !== (w == 1) || dma_ack !== (w == 2) || grant_dma !== (w == 2)) begin
            errors++;
            $display("FAIL rand_ack cyc %0d got cpu %b dma %b grant %b exp winner %0d", c, cpu_ack, dma_ack, grant_dma, w);
         end
         checks++;
         if (mem_addr !== eAddr || mem_wdata !== eWdata || mem_ctrl !== eCtrl) begin
            errors++;
            $display("FAIL rand_mem cyc %0d got %h %h %b exp %h %h %b", c, mem_addr, mem_wdata, mem_ctrl, eAddr, eWdata, eCtrl);
         end
         checks++;
         if (cpu_rvalid !== eCpuRv || cpu_rdata !== eCpuRd) begin
            errors++;
            $display("FAIL rand_cpu_rd cyc %0d got %b %h exp %b %h", c, cpu_rvalid, cpu_rdata, eCpuRv, eCpuRd);
         end
         checks++;
         if (dma_rvalid !== eDmaRv || dma_rdata !== eDmaRd) begin
            errors++;
            $display("FAIL rand_dma_rd cyc %0d got %b %h exp %b %h", c, dma_rvalid, dma_rdata, eDmaRv, eDmaRd);
         end
         tick();
      end
      init = 1'b0;
      idle();
      tick();
   endtask

   initial begin
      pWe = 1'b0; pIdx = '0; pData = '0;
      init = 1'b1;
      idle();
      preload();
      test_reset();
      test_cpu_read();
      test_contention();
      test_dma_write();
      test_lock_burst();
      test_lock_drop_init();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the memory's data port (port B: read/write, with a 4-bit control bus) between two requesters: the CPU load/store unit and a secondary DMA/loader master. Each cycle at most one request is granted. The CPU has fixed priority, bounded by a DMA starvation limit. The DMA may lock the port for bounded bursts. The block sits between the CPU data-side bus and the memory's port-B pins; the instruction port (A) is untouched.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA outranks CPU (≥1)
- LOCK_MAX, 16, max granted DMA beats per locked burst (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- init  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; held with stable payload until cpu_ack
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_ctrl  in  4  {write, half, byte, ext}
- cpu_ack  out  1  CPU access performed this cycle (combinational)
- cpu_rdata  out  DW  registered read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- dma_req, dma_addr, dma_wdata, dma_ctrl, dma_ack, dma_rdata, dma_rvalid: same as CPU set, DMA side
- dma_lock  in  1  DMA requests exclusive ownership across beats
- mem_addr  out  AW  to memory port B address (read and write)
- mem_wdata  out  DW  to memory write data
- mem_ctrl  out  4  to memory {we, half, byte, ext}
- mem_rdata  in  DW  memory port B read data (combinational from mem_addr)
- grant_dma  out  1  current winner is DMA (debug/observability)

## Operation
- States: ARB, LOCK. Reset → ARB.
- Winner selection in ARB:
  - If starve_cnt ≥ STARVE_LIMIT and dma_req, DMA wins.
  - Else CPU wins if cpu_req.
  - Else DMA wins if dma_req.
  - Else no winner.
- Winner selection in LOCK: DMA wins iff dma_req; CPU is never acked.
- Winner muxes its addr/wdata/ctrl onto mem_*; its ack is high the same cycle.
- No winner: mem_addr=0, mem_wdata=0, mem_ctrl=0, so no write can occur.
- Writes (ctrl[3]=1) commit at the clock edge ending the ack cycle. No rvalid is produced for writes.
- Reads: mem_rdata is captured into the winner's rdata register at the ack-cycle edge. Its rvalid pulses the following cycle.
- The other requester's rdata register holds its value.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments when dma_req && !dma_ack.
  - Clears on dma_ack or !dma_req.
- ARB → LOCK: at the end of a cycle where DMA is acked with dma_lock=1. lock_cnt is set to 1.
- In LOCK, each DMA ack increments lock_cnt.
- LOCK → ARB at end of cycle when any of the following holds:
  - dma_lock=0
  - lock_cnt reaches LOCK_MAX on an acked beat
  - init
- On a forced LOCK_MAX exit, starve_cnt clears. The CPU therefore wins the next ARB cycle if requesting.
- Simultaneous cpu_req and dma_req with starve_cnt < LIMIT: CPU acked, DMA waits.
- Requests dropped before ack: allowed. No state is corrupted and no ack is issued.
- init mid-operation: state, counters, rvalids and rdatas are cleared at that edge. A write acked in the init cycle still commits (memory is not reset).

## Timing
- Reset values: cpu_ack=dma_ack=0 while init=1. cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=0, grant_dma=0, mem_ctrl=0, mem_addr=0, mem_wdata=0. starve_cnt=0, lock_cnt=0, state=ARB.
- Ack latency: 0 cycles after req (same cycle) when winning.
- Read-data latency: rvalid 1 cycle after ack.
- Throughput: one access per cycle total. Back-to-back acks to the same requester are permitted.
- Worst-case DMA wait with continuous CPU traffic: STARVE_LIMIT cycles.
- Worst-case CPU wait behind a lock: LOCK_MAX DMA beats, plus idle cycles while dma_lock=1 and dma_req=0.

## Structure
- Shared package mem_bus_pkg:
  - Control-bit indices CTRL_WE=3, CTRL_HALF=2, CTRL_BYTE=1, CTRL_EXT=0.
  - State enum {ARB, LOCK}.
  - ctrl width constant 4.
- One sub-module: sat_counter (width and limit parameters; inc, clr; count, at_limit), instantiated twice for starve_cnt and lock_cnt.
- Winner mux and FSM live in the top.

## Test plan
- Reset: init=1 for 2 cycles with both reqs high → no acks, mem_ctrl=0, all rvalid=0, rdata=0.
- CPU-only read at 0x10 (ctrl 0000), memory returns 0xDEADBEEF → cpu_ack same cycle, cpu_rvalid next cycle with cpu_rdata=0xDEADBEEF, dma_rvalid=0.
- Contention: cpu_req held high continuously, dma_req high → CPU acked cycles 0–7. DMA acked on cycle 8 (STARVE_LIMIT=8), CPU acked cycle 9.
- DMA write 0xA5A5A5A5 to 0x40 (ctrl 1000) with no CPU traffic → mem_ctrl=1000 for exactly one cycle, no dma_rvalid, read-back via CPU returns 0xA5A5A5A5.
- Lock burst: dma_lock=1, dma_req continuous, cpu_req continuous from cycle 1 → exactly 16 DMA acks, then CPU acked next cycle, starve_cnt=0.
- Lock dropped after 3 beats: CPU acked the cycle after dma_lock falls. Asserting init mid-lock returns to ARB with no ack during init.
